// File: rtl/mmc_spi_slave.sv
// SPI mode-0 slave with an SOPC-style register window (rxdata/txdata/status/control/eop).
// SCLK, SS_n and MOSI are oversampled in the clk domain; all frame logic runs on detected pin edges.
module mmc_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket
);

  // state  | meaning
  // IDLE   | waiting for a fresh SS_n fall
  // ACTIVE | frame in progress, shifting on SCLK edges
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  localparam logic [2:0]  A_RXDATA  = 3'd0;
  localparam logic [2:0]  A_TXDATA  = 3'd1;
  localparam logic [2:0]  A_STATUS  = 3'd2;
  localparam logic [2:0]  A_CONTROL = 3'd3;
  localparam logic [2:0]  A_EOP     = 3'd6;
  localparam logic [15:0] CTRL_MASK = 16'h03D8;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d;
  logic ss_prev_q, ss_prev_d;

  logic [DATABITS-1:0] shift_q, shift_d;
  logic [DATABITS-2:0] rx_shift_q, rx_shift_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic                reload_q, reload_d;
  logic [DATABITS-1:0] rx_hold_q, rx_hold_d;
  logic [DATABITS-1:0] tx_hold_q, tx_hold_d;
  logic                tx_primed_q, tx_primed_d;
  logic                rrdy_q, rrdy_d;
  logic                roe_q, roe_d;
  logic                toe_q, toe_d;
  logic                eopf_q, eopf_d;
  logic [15:0]         ctrl_q, ctrl_d;
  logic [15:0]         eop_val_q, eop_val_d;
  logic [15:0]         dout_q, dout_d;
  logic                irq_q, irq_d;
  logic                acc_busy_q, acc_busy_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic rd_first, wr_first;
  logic frame_active, trdy, tmt;
  logic load_evt, rx_done;
  logic [DATABITS-1:0] rx_byte;
  logic [15:0] status;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  // A bus access spans two cycles; only its first cycle acts.
  assign rd_first = spi_select & ~read_n & ~acc_busy_q;
  assign wr_first = spi_select & ~write_n & ~acc_busy_q;

  assign frame_active = (state_q == ST_ACTIVE);
  assign trdy = ~tx_primed_q;
  assign tmt  = ~frame_active & ~tx_primed_q;

  always_comb begin
    status    = 16'h0000;
    status[9] = eopf_q;
    status[8] = roe_q | toe_q;
    status[7] = rrdy_q;
    status[6] = trdy;
    status[5] = tmt;
    status[4] = toe_q;
    status[3] = roe_q;
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    acc_busy_d  = spi_select & (~read_n | ~write_n) & ~acc_busy_q;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rx_shift_d  = rx_shift_q;
    bitcnt_d    = bitcnt_q;
    reload_d    = reload_q;
    rx_hold_d   = rx_hold_q;
    tx_hold_d   = tx_hold_q;
    tx_primed_d = tx_primed_q;
    rrdy_d      = rrdy_q;
    roe_d       = roe_q;
    toe_d       = toe_q;
    eopf_d      = eopf_q;
    ctrl_d      = ctrl_q;
    eop_val_d   = eop_val_q;
    dout_d      = dout_q;
    irq_d       = |(status & ctrl_q);
    load_evt    = 1'b0;
    rx_done     = 1'b0;
    rx_byte     = {rx_shift_q, mosi_s};

    // CPU-side clears come first so that pin-side set events override them.
    if (wr_first && mem_addr == A_STATUS) begin
      eopf_d = 1'b0;
      rrdy_d = 1'b0;
      roe_d  = 1'b0;
      toe_d  = 1'b0;
    end
    if (rd_first && mem_addr == A_RXDATA) rrdy_d = 1'b0;
    if (wr_first && mem_addr == A_CONTROL) ctrl_d = data_from_cpu & CTRL_MASK;
    if (wr_first && mem_addr == A_EOP) eop_val_d = data_from_cpu;

    if (rd_first) begin
      case (mem_addr)
        A_RXDATA:  dout_d = {{(16-DATABITS){1'b0}}, rx_hold_q};
        A_STATUS:  dout_d = status;
        A_CONTROL: dout_d = ctrl_q;
        A_EOP:     dout_d = eop_val_q;
        default:   dout_d = 16'h0000;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          load_evt = 1'b1;
          bitcnt_d = 3'd0;
          reload_d = 1'b0;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          bitcnt_d = 3'd0;
          reload_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte[DATABITS-2:0];
          bitcnt_d   = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DATABITS-1)) begin
            rx_done  = 1'b1;
            bitcnt_d = 3'd0;
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            load_evt = 1'b1;
            reload_d = 1'b0;
          end else begin
            shift_d = shift_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_done) begin
      rx_hold_d = rx_byte;
      rrdy_d    = 1'b1;
      reload_d  = 1'b1;
      if (rrdy_q) roe_d = 1'b1;
      if (rx_byte == eop_val_q[DATABITS-1:0]) eopf_d = 1'b1;
    end

    if (load_evt) begin
      if (tx_primed_q) begin
        shift_d = tx_hold_q;
      end else begin
        shift_d = {DATABITS{1'b1}};
        toe_d   = 1'b1;
      end
      tx_primed_d = 1'b0;
    end

    // A write coinciding with a load is accepted: the load already took the old byte.
    if (wr_first && mem_addr == A_TXDATA) begin
      if (tx_primed_q && !load_evt) begin
        toe_d = 1'b1;
      end else begin
        tx_hold_d   = data_from_cpu[DATABITS-1:0];
        tx_primed_d = 1'b1;
      end
    end
  end

  // SS_n chain resets low so a select already asserted at release cannot look like a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      bitcnt_q    <= 3'd0;
      reload_q    <= 1'b0;
      rx_hold_q   <= '0;
      tx_hold_q   <= '0;
      tx_primed_q <= 1'b0;
      rrdy_q      <= 1'b0;
      roe_q       <= 1'b0;
      toe_q       <= 1'b0;
      eopf_q      <= 1'b0;
      ctrl_q      <= 16'h0000;
      eop_val_q   <= 16'h0000;
      dout_q      <= 16'h0000;
      irq_q       <= 1'b0;
      acc_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      bitcnt_q    <= bitcnt_d;
      reload_q    <= reload_d;
      rx_hold_q   <= rx_hold_d;
      tx_hold_q   <= tx_hold_d;
      tx_primed_q <= tx_primed_d;
      rrdy_q      <= rrdy_d;
      roe_q       <= roe_d;
      toe_q       <= toe_d;
      eopf_q      <= eopf_d;
      ctrl_q      <= ctrl_d;
      eop_val_q   <= eop_val_d;
      dout_q      <= dout_d;
      irq_q       <= irq_d;
      acc_busy_q  <= acc_busy_d;
    end
  end

  assign MISO          = shift_q[DATABITS-1];
  assign MISO_oe       = frame_active;
  assign data_to_cpu   = dout_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = trdy;
  assign endofpacket   = eopf_q;

endmodule

// File: tb/tb_mmc_spi_slave.sv
// Bench for mmc_spi_slave: a mode-0 master drives frames, a flag-level model predicts MISO and registers.
module tb_mmc_spi_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK, SS_n, MOSI;
  logic        MISO, MISO_oe;
  logic        spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata, endofpacket;

  int n_checks = 0;
  int n_fail   = 0;

  mmc_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .read_n(read_n),
    .write_n(write_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .endofpacket(endofpacket)
  );

  always #5 clk = ~clk;

  // reference model: register-level flags only
  logic       m_primed, m_rrdy, m_roe, m_toe, m_eop;
  logic [7:0] m_hold, m_rx;
  logic [15:0] m_ctrl, m_eopv;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0;
    m_hold = 0; m_rx = 0; m_ctrl = 0; m_eopv = 0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[9] = m_eop; s[8] = m_roe | m_toe; s[7] = m_rrdy;
    s[6] = ~m_primed; s[5] = ~m_primed; s[4] = m_toe; s[3] = m_roe;
    return s;
  endfunction

  task automatic m_load(output logic [7:0] b);
    if (m_primed) b = m_hold;
    else begin b = 8'hFF; m_toe = 1; end
    m_primed = 0;
  endtask

  task automatic m_txwrite(input logic [7:0] d);
    if (m_primed) m_toe = 1;
    else begin m_hold = d; m_primed = 1; end
  endtask

  task automatic m_recv(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1; m_rx = b;
    if (b == m_eopv[7:0]) m_eop = 1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    @(negedge clk); @(negedge clk);
    spi_select = 0; write_n = 1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1; read_n = 0; mem_addr = a;
    @(negedge clk); @(negedge clk);
    spi_select = 0; read_n = 1;
    d = data_to_cpu;
  endtask

  task automatic spi_frame(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit tail_fall, input bit mid_wr,
                           input logic [7:0] mid_d, input bit lat_chk);
    logic [7:0] tx [3];
    logic [7:0] exp, got, dummy;
    bit last;
    tx[0] = b0; tx[1] = b1; tx[2] = b2;
    SS_n = 0;
    m_load(exp);
    repeat (6) @(negedge clk);
    if (mid_wr) begin
      bus_write(3'd1, {8'h00, mid_d});
      m_txwrite(mid_d);
    end
    for (int k = 0; k < nbytes; k++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        last = (k == nbytes - 1) && (i == 7);
        MOSI = tx[k][7-i];
        repeat (5) @(negedge clk);
        got = {got[6:0], MISO};
        SCLK = 1;
        if (i == 7) m_recv(tx[k]);
        if (last && lat_chk) begin
          repeat (2) @(negedge clk);
          chk("eop_lat_early", {15'h0, endofpacket}, 16'h0);
          @(negedge clk);
          chk("eop_lat", {15'h0, endofpacket}, 16'h1);
          chk("rrdy_lat", {15'h0, dataavailable}, 16'h1);
          chk("irq_lat_early", {15'h0, irq}, 16'h0);
          @(negedge clk);
          chk("irq_lat", {15'h0, irq}, 16'h1);
          @(negedge clk);
        end else begin
          repeat (5) @(negedge clk);
        end
        if (last && !tail_fall) begin
          SS_n = 1;
          repeat (5) @(negedge clk);
          SCLK = 0;
        end else begin
          SCLK = 0;
        end
      end
      chk($sformatf("miso_byte%0d", k), {8'h0, got}, {8'h0, exp});
      if (k < nbytes - 1) m_load(exp);
    end
    if (tail_fall) begin
      m_load(dummy);
      repeat (5) @(negedge clk);
      SS_n = 1;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_partial(input int nbits, input logic [7:0] b);
    logic [7:0] dummy;
    SS_n = 0;
    m_load(dummy);
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[7-i];
      repeat (5) @(negedge clk);
      SCLK = 1;
      repeat (5) @(negedge clk);
      SCLK = 0;
    end
    repeat (5) @(negedge clk);
    SS_n = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    logic [15:0] r;
    bus_read(3'd2, r);
    chk(tag, r, m_status());
  endtask

  task automatic check_rx(input string tag);
    logic [15:0] r;
    bus_read(3'd0, r);
    chk(tag, r, {8'h0, m_rx});
    m_rrdy = 0;
  endtask

  task automatic clear_status();
    bus_write(3'd2, 16'hFFFF);
    m_eop = 0; m_rrdy = 0; m_roe = 0; m_toe = 0;
  endtask

  initial begin
    logic [15:0] r, d;
    logic [7:0] bb [3];
    int n;

    reset = 1; SCLK = 0; SS_n = 1; MOSI = 0;
    spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0; data_from_cpu = 0;
    m_reset();
    repeat (4) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);

    chk("rst_miso", {15'h0, MISO}, 16'h0);
    chk("rst_oe", {15'h0, MISO_oe}, 16'h0);
    chk("rst_dout", data_to_cpu, 16'h0);
    chk("rst_irq", {15'h0, irq}, 16'h0);
    chk("rst_trdy", {15'h0, readyfordata}, 16'h1);
    check_status("rst_status");
    bus_read(3'd3, r);
    chk("rst_control", r, 16'h0);

    // primed byte
    bus_write(3'd1, 16'h00A5); m_txwrite(8'hA5);
    spi_frame(1, 8'h3C, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    check_status("primed_status");
    check_rx("primed_rx");

    // underrun, two bytes in one frame
    spi_frame(2, 8'h11, 8'h22, 8'h00, 0, 0, 8'h00, 0);
    check_status("underrun_status");
    check_rx("underrun_rx");
    clear_status();

    // back-to-back tx writes, refill during the first byte
    bus_write(3'd1, 16'h0001); m_txwrite(8'h01);
    bus_write(3'd1, 16'h0002); m_txwrite(8'h02);
    check_status("b2b_toe");
    spi_frame(2, 8'h5A, 8'h6B, 8'h00, 0, 1, 8'h03, 0);
    check_status("b2b_status");
    clear_status();
    check_rx("b2b_rx");

    // EOP and irq timing
    bus_write(3'd6, 16'h007E); m_eopv = 16'h007E;
    bus_write(3'd3, 16'h0200); m_ctrl = 16'h0200;
    bus_read(3'd3, r);
    chk("ctrl_read", r, m_ctrl);
    spi_frame(1, 8'h7E, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    check_status("eop_status");
    clear_status();
    repeat (2) @(negedge clk);
    chk("eop_cleared", {15'h0, endofpacket}, 16'h0);
    chk("irq_cleared", {15'h0, irq}, 16'h0);

    // abort after 5 bits, then a full frame
    spi_partial(5, 8'hF0);
    chk("abort_rrdy", {15'h0, dataavailable}, {15'h0, m_rrdy});
    check_status("abort_status");
    spi_frame(1, 8'hC3, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    check_rx("abort_rx");
    clear_status();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        bus_write(3'd1, d); m_txwrite(d[7:0]);
      end
      if ($urandom_range(0, 3) == 0) begin
        d = 16'($urandom);
        bus_write(3'd6, d); m_eopv = d;
      end
      if ($urandom_range(0, 3) == 0) begin
        d = 16'($urandom);
        bus_write(3'd3, d); m_ctrl = d & 16'h03D8;
      end
      n = $urandom_range(1, 3);
      for (int j = 0; j < 3; j++) bb[j] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) bb[n-1] = m_eopv[7:0];
      spi_frame(n, bb[0], bb[1], bb[2], bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), 8'($urandom), 0);
      chk("rnd_irq", {15'h0, irq}, {15'h0, |(m_status() & m_ctrl)});
      check_status("rnd_status");
      if ($urandom_range(0, 1) == 1) check_rx("rnd_rx");
      if ($urandom_range(0, 2) == 0) clear_status();
      repeat (2) @(negedge clk);
    end

    // reset mid-frame with SS_n held low
    SS_n = 0;
    repeat (6) @(negedge clk);
    MOSI = 1; repeat (5) @(negedge clk); SCLK = 1; repeat (5) @(negedge clk);
    reset = 1; SCLK = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("mrst_miso", {15'h0, MISO}, 16'h0);
    chk("mrst_oe", {15'h0, MISO_oe}, 16'h0);
    chk("mrst_dout", data_to_cpu, 16'h0);
    chk("mrst_irq", {15'h0, irq}, 16'h0);
    chk("mrst_rrdy", {15'h0, dataavailable}, 16'h0);
    chk("mrst_trdy", {15'h0, readyfordata}, 16'h1);
    chk("mrst_eop", {15'h0, endofpacket}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      MOSI = i[0];
      repeat (5) @(negedge clk); SCLK = 1;
      repeat (5) @(negedge clk); SCLK = 0;
    end
    repeat (4) @(negedge clk);
    chk("mrst_noframe_rrdy", {15'h0, dataavailable}, 16'h0);
    chk("mrst_noframe_oe", {15'h0, MISO_oe}, 16'h0);
    SS_n = 1;
    repeat (6) @(negedge clk);
    spi_frame(1, 8'h96, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    check_status("mrst_status");
    check_rx("mrst_rx");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
